// File: rtl/key_debounce.sv
// Four-key synchroniser/debouncer with registered level and press/release pulses.
// Optional long-press pulse per key when KEY_LONG_PRESS_EN is defined.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CNT = 1_000_000,
  parameter int unsigned LONG_CNT     = 50_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [3:0] key_n,
  output logic [3:0] key_state,
  output logic [3:0] key_press,
  output logic [3:0] key_release,
  output logic [3:0] key_long
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } state_t;

  if (DEBOUNCE_CNT < 2 || LONG_CNT < 1) begin : g_bad_params
    $error("key_debounce: DEBOUNCE_CNT must be >= 2 and LONG_CNT >= 1");
  end

  // Two-flop synchroniser; resets to the released (high) level.
  logic [3:0] s1;
  logic [3:0] s2;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= key_n;
      s2 <= s1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_key
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          press_nxt;
    logic          release_nxt;
    logic          pressed_q;
    logic          press_q;
    logic          release_q;

    always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      unique case (state)
        IDLE: begin
          if (!s2[g]) begin
            state_nxt = PRESS_DB;
            cnt_nxt   = CW'(1);
          end
        end
        PRESS_DB: begin
          if (s2[g]) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt == DB_MAX) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
            press_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        HELD: begin
          if (s2[g]) begin
            state_nxt = RELEASE_DB;
            cnt_nxt   = CW'(1);
          end
        end
        RELEASE_DB: begin
          if (!s2[g]) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
          end else if (cnt == DB_MAX) begin
            state_nxt   = IDLE;
            cnt_nxt     = '0;
            release_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    // Level and pulses are registered from the next-state decode so they
    // change on the same edge as the FSM transition.
    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        state     <= IDLE;
        cnt       <= '0;
        pressed_q <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state     <= state_nxt;
        cnt       <= cnt_nxt;
        pressed_q <= (state_nxt == HELD) || (state_nxt == RELEASE_DB);
        press_q   <= press_nxt;
        release_q <= release_nxt;
      end
    end

    assign key_state[g]   = pressed_q;
    assign key_press[g]   = press_q;
    assign key_release[g] = release_q;

`ifdef KEY_LONG_PRESS_EN
    localparam int unsigned LW = $clog2(LONG_CNT + 1);
    localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CNT);
    localparam logic [LW-1:0] LONG_PRE = LW'(LONG_CNT - 1);

    logic [LW-1:0] lcnt;
    logic [LW-1:0] lcnt_nxt;
    logic          long_nxt;
    logic          long_q;

    // Only the PRESS_DB->HELD entry restarts the count; a release bounce
    // back into HELD keeps accumulating, and saturation gives one pulse.
    always_comb begin
      lcnt_nxt = lcnt;
      long_nxt = 1'b0;
      if (state_nxt == IDLE) begin
        lcnt_nxt = '0;
      end else if (state == PRESS_DB && state_nxt == HELD) begin
        lcnt_nxt = '0;
      end else if ((state == HELD || state == RELEASE_DB) && lcnt != LONG_MAX) begin
        lcnt_nxt = lcnt + LW'(1);
        long_nxt = (lcnt == LONG_PRE);
      end
    end

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        lcnt   <= '0;
        long_q <= 1'b0;
      end else begin
        lcnt   <= lcnt_nxt;
        long_q <= long_nxt;
      end
    end

    assign key_long[g] = long_q;
`endif
  end

`ifndef KEY_LONG_PRESS_EN
  assign key_long = '0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CNT=8, LONG_CNT=32.
// Inputs and checks happen 1 time unit after each rising edge.
module tb_key_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_n;
  logic [3:0] key_state;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_long;

  int checks = 0;
  int errors = 0;

  key_debounce #(
    .DEBOUNCE_CNT(8),
    .LONG_CNT    (32)
  ) dut (
    .sys_clk    (clk),
    .sys_rst    (rst),
    .key_n      (key_n),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] st, input logic [3:0] pr,
                         input logic [3:0] rl, input logic [3:0] lg);
    chk({tag, ".state"}, key_state, st);
    chk({tag, ".press"}, key_press, pr);
    chk({tag, ".release"}, key_release, rl);
    chk({tag, ".long"}, key_long, lg);
  endtask

  // n-1 quiet cycles, the event on cycle n, then one quiet cycle after it.
  task automatic wait_expect(input string tag, input int n, input logic [3:0] st_before,
                             input logic [3:0] st_after, input logic [3:0] pr,
                             input logic [3:0] rl);
    for (int i = 1; i < n; i++) begin
      tick();
      chk_out({tag, ".wait"}, st_before, 4'b0000, 4'b0000, 4'b0000);
    end
    tick();
    chk_out({tag, ".event"}, st_after, pr, rl, 4'b0000);
    tick();
    chk_out({tag, ".after"}, st_after, 4'b0000, 4'b0000, 4'b0000);
  endtask

  task automatic release_keys(input string tag, input logic [3:0] st_before);
    key_n = 4'b1111;
    wait_expect(tag, 11, st_before, 4'b0000, 4'b0000, st_before);
  endtask

  initial begin
    logic [3:0] exp_long;

    // Reset state
    rst   = 1'b1;
    key_n = 4'b1111;
    tick();
    chk_out("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick();
    rst = 1'b0;
    tick();
    chk_out("idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Clean press/release on key 0: 20 low samples, then high.
    key_n = 4'b1110;
    wait_expect("clean_press", 11, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_out("clean_hold", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    end
    key_n = 4'b1111;
    wait_expect("clean_release", 11, 4'b0001, 4'b0000, 4'b0000, 4'b0001);

    // Glitch on key 1: 7 low samples must not register.
    key_n = 4'b1101;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_out("glitch_low", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end
    key_n = 4'b1111;
    for (int i = 0; i < 14; i++) begin
      tick();
      chk_out("glitch_after", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end

    // Bounce on key 2: toggle every 3 cycles for 30 cycles, then settle low.
    for (int seg = 0; seg < 10; seg++) begin
      key_n = (seg % 2 == 0) ? 4'b1011 : 4'b1111;
      for (int i = 0; i < 3; i++) begin
        tick();
        chk_out("bounce", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      end
    end
    key_n = 4'b1011;
    wait_expect("bounce_settle", 11, 4'b0000, 4'b0100, 4'b0100, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("bounce_hold", 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    end
    release_keys("bounce_release", 4'b0100);

    // Keys 1 and 3 fall on the same edge.
    key_n = 4'b0101;
    wait_expect("simul_press", 11, 4'b0000, 4'b1010, 4'b1010, 4'b0000);
    release_keys("simul_release", 4'b1010);

    // Reset during press debounce; held key is re-debounced from zero.
    key_n = 4'b1110;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("rst_pre", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end
    rst = 1'b1;
    tick();
    chk_out("rst_during", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b0;
    wait_expect("rst_redebounce", 11, 4'b0000, 4'b0001, 4'b0001, 4'b0000);

    // Reset while HELD drops the level at once, then re-presses.
    rst = 1'b1;
    tick();
    chk_out("rst_held", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b0;
    wait_expect("rst_held_repress", 11, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    release_keys("rst_release", 4'b0001);

    // Long press: key 0 low for 60 cycles; press at cycle 11, long at 43.
    key_n = 4'b1110;
    for (int t = 1; t <= 60; t++) begin
      tick();
`ifdef KEY_LONG_PRESS_EN
      exp_long = (t == 43) ? 4'b0001 : 4'b0000;
`else
      exp_long = 4'b0000;
`endif
      chk_out("long", (t >= 11) ? 4'b0001 : 4'b0000,
              (t == 11) ? 4'b0001 : 4'b0000, 4'b0000, exp_long);
    end
    release_keys("long_release", 4'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
